// File: rtl/arp_ctrl_if.sv
// rtl/arp_ctrl_if.sv - ARP controller bus: rx parser events, user resolve, transmitter handshake, peer cache

interface arp_ctrl_if;
    logic        rx_valid;
    logic        rx_is_reply;
    logic [47:0] rx_src_mac;
    logic [31:0] rx_src_ip;
    logic        user_req;
    logic [31:0] user_req_ip;
    logic        tx_start;
    logic        tx_is_reply;
    logic [47:0] tx_des_mac;
    logic [31:0] tx_des_ip;
    logic        tx_busy;
    logic        tx_done;
    logic [47:0] peer_mac;
    logic [31:0] peer_ip;
    logic        peer_valid;
    logic        resolve_fail;

    modport master (
        input  rx_valid, rx_is_reply, rx_src_mac, rx_src_ip,
        input  user_req, user_req_ip,
        input  tx_busy, tx_done,
        output tx_start, tx_is_reply, tx_des_mac, tx_des_ip,
        output peer_mac, peer_ip, peer_valid, resolve_fail
    );

    modport slave (
        output rx_valid, rx_is_reply, rx_src_mac, rx_src_ip,
        output user_req, user_req_ip,
        output tx_busy, tx_done,
        input  tx_start, tx_is_reply, tx_des_mac, tx_des_ip,
        input  peer_mac, peer_ip, peer_valid, resolve_fail
    );
endinterface

// File: rtl/arp_ctrl.sv
// rtl/arp_ctrl.sv - ARP transmit sequencer, single-entry peer cache and request timeout/retry
// Optional: ARP_GRATUITOUS_EN sends one gratuitous request right after reset release.

module arp_ctrl #(
    parameter logic [31:0] BOARD_IP       = 32'h0,
    parameter logic [47:0] DES_MAC        = 48'h2c_f0_5d_32_f1_07,
    parameter logic [31:0] DES_IP         = 32'h0,
    parameter int unsigned REFRESH_CYCLES = 125_000_000,
    parameter int unsigned REPLY_TIMEOUT  = 12_500_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        gmii_rx_clk,
    input  logic        rstn,
    arp_ctrl_if.master  ctrl_io
);

    localparam logic [47:0] BCAST_MAC = 48'hff_ff_ff_ff_ff_ff;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TW = (REPLY_TIMEOUT > 0) ? $clog2(REPLY_TIMEOUT + 1) : 1;
    localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

`ifdef ARP_GRATUITOUS_EN
    localparam logic GRAT_INIT = 1'b1;
`else
    localparam logic GRAT_INIT = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_DONE, S_WAIT_REPLY} state_t;
    typedef enum logic [1:0] {K_REPLY, K_REQUEST, K_GRAT} kind_t;

    state_t      state_q;
    kind_t       kind_q;
    logic        grat_q;
    logic        rep_pend_q;
    logic [47:0] rep_mac_q;
    logic [31:0] rep_ip_q;
    logic        usr_pend_q;
    logic [31:0] usr_ip_q;
    logic        ref_pend_q;
    logic [RW-1:0] ref_cnt_q;
    logic [RW-1:0] ref_cnt_d;
    logic        req_out_q;
    logic [31:0] tgt_ip_q;
    logic [TW-1:0] tmo_q;
    logic [CW-1:0] retry_q;
    logic        tx_start_q;
    logic        tx_is_reply_q;
    logic [47:0] tx_des_mac_q;
    logic [31:0] tx_des_ip_q;
    logic [47:0] peer_mac_q;
    logic [31:0] peer_ip_q;
    logic        peer_valid_q;
    logic        resolve_fail_q;

    logic rx_req;
    logic rx_match;
    logic ref_hit;

    assign rx_req   = ctrl_io.rx_valid && !ctrl_io.rx_is_reply;
    assign rx_match = ctrl_io.rx_valid && ctrl_io.rx_is_reply && req_out_q &&
                      (ctrl_io.rx_src_ip == tgt_ip_q) && (ctrl_io.rx_src_ip != BOARD_IP);
    assign ref_hit  = (ref_cnt_q == RW'(REFRESH_CYCLES - 1));

    always_comb begin
        ref_cnt_d = ref_hit ? '0 : ref_cnt_q + RW'(1);
    end

    always_ff @(posedge gmii_rx_clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            kind_q         <= K_REPLY;
            grat_q         <= GRAT_INIT;
            rep_pend_q     <= 1'b0;
            rep_mac_q      <= '0;
            rep_ip_q       <= '0;
            usr_pend_q     <= 1'b0;
            usr_ip_q       <= '0;
            ref_pend_q     <= 1'b0;
            ref_cnt_q      <= '0;
            req_out_q      <= 1'b0;
            tgt_ip_q       <= '0;
            tmo_q          <= '0;
            retry_q        <= '0;
            tx_start_q     <= 1'b0;
            tx_is_reply_q  <= 1'b0;
            tx_des_mac_q   <= '0;
            tx_des_ip_q    <= '0;
            peer_mac_q     <= DES_MAC;
            peer_ip_q      <= DES_IP;
            peer_valid_q   <= 1'b0;
            resolve_fail_q <= 1'b0;
        end else begin
            resolve_fail_q <= 1'b0;
            ref_cnt_q      <= ref_cnt_d;
            if (req_out_q && tmo_q != '0)
                tmo_q <= tmo_q - TW'(1);

            case (state_q)
                S_IDLE: begin
                    if (!ctrl_io.tx_busy) begin
                        if (grat_q) begin
                            grat_q        <= 1'b0;
                            kind_q        <= K_GRAT;
                            tx_is_reply_q <= 1'b0;
                            tx_des_mac_q  <= BCAST_MAC;
                            tx_des_ip_q   <= BOARD_IP;
                            tx_start_q    <= 1'b1;
                            state_q       <= S_SEND;
                        end else if (rep_pend_q) begin
                            rep_pend_q    <= 1'b0;
                            kind_q        <= K_REPLY;
                            tx_is_reply_q <= 1'b1;
                            tx_des_mac_q  <= rep_mac_q;
                            tx_des_ip_q   <= rep_ip_q;
                            tx_start_q    <= 1'b1;
                            state_q       <= S_SEND;
                        end else if (usr_pend_q) begin
                            usr_pend_q    <= 1'b0;
                            kind_q        <= K_REQUEST;
                            tgt_ip_q      <= usr_ip_q;
                            retry_q       <= '0;
                            tx_is_reply_q <= 1'b0;
                            tx_des_mac_q  <= BCAST_MAC;
                            tx_des_ip_q   <= usr_ip_q;
                            tx_start_q    <= 1'b1;
                            state_q       <= S_SEND;
                        end else if (ref_pend_q) begin
                            ref_pend_q    <= 1'b0;
                            kind_q        <= K_REQUEST;
                            tgt_ip_q      <= peer_ip_q;
                            retry_q       <= '0;
                            tx_is_reply_q <= 1'b0;
                            tx_des_mac_q  <= BCAST_MAC;
                            tx_des_ip_q   <= peer_ip_q;
                            tx_start_q    <= 1'b1;
                            state_q       <= S_SEND;
                        end
                    end
                end
                // tx_start is armed only when the transmitter was seen idle
                S_SEND: begin
                    if (tx_start_q) begin
                        tx_start_q <= 1'b0;
                        state_q    <= S_WAIT_DONE;
                    end else if (!ctrl_io.tx_busy) begin
                        tx_start_q <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (ctrl_io.tx_done) begin
                        case (kind_q)
                            K_REQUEST: begin
                                req_out_q <= 1'b1;
                                tmo_q     <= TW'(REPLY_TIMEOUT);
                                state_q   <= S_WAIT_REPLY;
                            end
                            K_REPLY:  state_q <= req_out_q ? S_WAIT_REPLY : S_IDLE;
                            default:  state_q <= S_IDLE;
                        endcase
                    end
                end
                S_WAIT_REPLY: begin
                    if (rx_match || !req_out_q) begin
                        state_q <= S_IDLE;
                    end else if (rep_pend_q) begin
                        rep_pend_q    <= 1'b0;
                        kind_q        <= K_REPLY;
                        tx_is_reply_q <= 1'b1;
                        tx_des_mac_q  <= rep_mac_q;
                        tx_des_ip_q   <= rep_ip_q;
                        tx_start_q    <= !ctrl_io.tx_busy;
                        state_q       <= S_SEND;
                    end else if (tmo_q == '0) begin
                        if (retry_q < CW'(MAX_RETRY)) begin
                            retry_q       <= retry_q + CW'(1);
                            kind_q        <= K_REQUEST;
                            tx_is_reply_q <= 1'b0;
                            tx_des_mac_q  <= BCAST_MAC;
                            tx_des_ip_q   <= tgt_ip_q;
                            tx_start_q    <= !ctrl_io.tx_busy;
                            state_q       <= S_SEND;
                        end else begin
                            resolve_fail_q <= 1'b1;
                            peer_valid_q   <= 1'b0;
                            req_out_q      <= 1'b0;
                            retry_q        <= '0;
                            state_q        <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Flag sets come after the FSM clears so a coincident event is never lost
            if (rx_req) begin
                rep_pend_q <= 1'b1;
                rep_mac_q  <= ctrl_io.rx_src_mac;
                rep_ip_q   <= ctrl_io.rx_src_ip;
            end
            if (ctrl_io.user_req) begin
                usr_pend_q <= 1'b1;
                usr_ip_q   <= ctrl_io.user_req_ip;
            end
            if (ref_hit && !req_out_q)
                ref_pend_q <= 1'b1;

            if (rx_req && ctrl_io.rx_src_ip != BOARD_IP) begin
                peer_mac_q   <= ctrl_io.rx_src_mac;
                peer_ip_q    <= ctrl_io.rx_src_ip;
                peer_valid_q <= 1'b1;
            end
            if (rx_match) begin
                peer_mac_q   <= ctrl_io.rx_src_mac;
                peer_ip_q    <= ctrl_io.rx_src_ip;
                peer_valid_q <= 1'b1;
                req_out_q    <= 1'b0;
                retry_q      <= '0;
            end
        end
    end

    assign ctrl_io.tx_start     = tx_start_q;
    assign ctrl_io.tx_is_reply  = tx_is_reply_q;
    assign ctrl_io.tx_des_mac   = tx_des_mac_q;
    assign ctrl_io.tx_des_ip    = tx_des_ip_q;
    assign ctrl_io.peer_mac     = peer_mac_q;
    assign ctrl_io.peer_ip      = peer_ip_q;
    assign ctrl_io.peer_valid   = peer_valid_q;
    assign ctrl_io.resolve_fail = resolve_fail_q;

endmodule

// File: doc/arp_ctrl.md
Name: arp_ctrl

Overview:
- Sequences a shared ARP transmitter for three requesters: replies owed to received ARP requests, user-triggered resolves, and periodic peer refresh.
- Maintains the single-entry peer cache (peer MAC/IP) consumed by the UDP TX path.
- Runs timeout/retry for outstanding requests.
- Sits between the ARP receive parser, the ARP frame transmitter and the UDP stack, entirely in the gmii_rx_clk domain.

Parameters:
- BOARD_IP, 32'h0, local IP; ignored as a cache source.
- DES_MAC, 48'h2c_f0_5d_32_f1_07, peer MAC cache reset value.
- DES_IP, 32'h0, peer IP cache reset value.
- REFRESH_CYCLES, 125_000_000, period of the automatic refresh request (1 s at 125 MHz).
- REPLY_TIMEOUT, 12_500_000, cycles to wait for an ARP reply after request tx_done.
- MAX_RETRY, 3, request retransmissions before failure.

Ports:
- gmii_rx_clk, in, 1, clock.
- rstn, in, 1, reset; asynchronous, active-low.
- rx_valid, in, 1, one-cycle pulse: parsed ARP frame addressed to BOARD_IP.
- rx_is_reply, in, 1, qualifies rx_valid; 0 = request (op 1), 1 = reply (op 2).
- rx_src_mac, in, 48, sender MAC of the frame; stable while rx_valid.
- rx_src_ip, in, 32, sender IP of the frame; stable while rx_valid.
- user_req, in, 1, pulse: resolve user_req_ip.
- user_req_ip, in, 32, target IP; sampled with user_req.
- tx_start, out, 1, one-cycle pulse to the ARP transmitter.
- tx_is_reply, out, 1, 0 = send request, 1 = send reply.
- tx_des_mac, out, 48, target MAC (48'hff_ff_ff_ff_ff_ff for requests).
- tx_des_ip, out, 32, target IP.
- tx_busy, in, 1, transmitter busy.
- tx_done, in, 1, pulse: frame fully sent.
- peer_mac, out, 48, cached peer MAC.
- peer_ip, out, 32, cached peer IP.
- peer_valid, out, 1, cache holds a resolved entry.
- resolve_fail, out, 1, pulse: retries exhausted.

Behaviour:
- Reset values: tx_start 0, tx_is_reply 0, tx_des_mac 0, tx_des_ip 0, peer_mac DES_MAC, peer_ip DES_IP, peer_valid 0, resolve_fail 0. All pending flags, counters and the FSM are cleared.
- Pending flags, each 1 deep:
  - rep_pend: set by rx_valid with rx_is_reply=0; latches rx_src_mac/ip as reply target. A later request overwrites the target before service (newest wins).
  - usr_pend: set by user_req; latches user_req_ip.
  - ref_pend: set when the free-running refresh counter reaches REFRESH_CYCLES-1 (wraps to 0). Target is peer_ip.
- Cache update:
  - rx_valid with rx_is_reply=0: peer_mac/peer_ip <= rx_src_mac/ip and peer_valid <= 1 next cycle.
  - Reply: the cache updates only if req_out=1 and rx_src_ip == the outstanding target IP. This clears req_out, clears the retry count and sets peer_valid.
  - rx_src_ip == BOARD_IP never updates the cache.
- FSM states:
  - IDLE: if tx_busy=0 and any flag is set, select by priority rep_pend > usr_pend > ref_pend. A user request replaces the outstanding target. Go to SEND.
  - SEND: drive tx_is_reply/tx_des_mac/tx_des_ip, pulse tx_start for exactly 1 cycle, clear the selected flag, go to WAIT_DONE.
  - WAIT_DONE: outputs held stable until tx_done. On tx_done: after a request, set req_out, load the timeout counter and go to WAIT_REPLY. After a reply, go to WAIT_REPLY if req_out=1, else IDLE.
  - WAIT_REPLY:
    - Counter decrements every cycle, including while a reply is being serviced.
    - Matching reply: go to IDLE.
    - rep_pend set: go to SEND for the reply, then return here.
    - Counter reaches 0, retries < MAX_RETRY: retry++, resend the same request via SEND.
    - Counter reaches 0, retries == MAX_RETRY: pulse resolve_fail 1 cycle, peer_valid <= 0, clear req_out, go to IDLE.
- tx_start never asserts while tx_busy=1; SEND waits.
- Simultaneous events: rx_valid coincident with a flag clear re-sets the flag (set wins). Refresh expiry while req_out=1 is dropped.
- Latency: an idle block with tx_busy=0 asserts tx_start 2 cycles after the rx_valid/user_req pulse.
- Reset mid-transaction: immediate return to the reset state. The transmitter is not aborted.

Optional Feature:
- ARP_GRATUITOUS_EN defined: the first transaction after reset release is a gratuitous request (tx_des_ip=BOARD_IP, broadcast MAC). It is sent ahead of all flags and is not timed out. After its tx_done, the FSM goes to IDLE.
- Not defined: the block idles after reset until a flag is set.

Test Plan:
- rx_valid, rx_is_reply=0, src 11:22:33:44:55:66 / 192.168.1.10, tx_busy=0 → tx_start 2 cycles later with tx_is_reply=1, those addresses; peer_valid=1, peer_ip=C0A8010A.
- user_req ip C0A80114, reply from C0A80114 mac AA.. before timeout → single request, peer_mac=AA.., no resolve_fail.
- REPLY_TIMEOUT=20, MAX_RETRY=3, no reply → 4 tx_start pulses spaced ≥20 cycles, then a 1-cycle resolve_fail and peer_valid=0.
- rx request and user_req in the same cycle → reply sent first, then request; tx outputs stable between tx_start and tx_done.
- Reply from a non-target IP during WAIT_REPLY → cache unchanged, retry proceeds. A request received during WAIT_REPLY → reply sent, wait resumes.
- REFRESH_CYCLES=100 → a broadcast request to peer_ip every 100 cycles while idle. rstn low mid-WAIT_DONE → all outputs at their reset values.
